// File: rtl/sd_io_sched_pkg.sv
// Shared types, defaults and helpers for the SD sector-path scheduler.
package sd_io_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_XFER,
        S_FIN
    } sched_state_t;

    localparam logic [23:0] DEF_TIMEOUT = 24'hFFFFFF;

    // Index following idx in a ring of n drives.
    function automatic logic [1:0] rr_next(input logic [1:0] idx, input int unsigned n);
        if (({30'd0, idx} + 32'd1) >= n) begin
            return 2'd0;
        end
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/sd_io_sched_rr_arbiter.sv
// Combinational round-robin pick over the per-drive request vector.
module rr_arbiter
    import sd_io_sched_pkg::*;
#(
    parameter int unsigned VDNUM = 3
) (
    input  logic [VDNUM-1:0] req,
    input  logic [1:0]       rr_ptr,
    output logic [1:0]       gnt_idx,
    output logic             gnt_valid
);

    int unsigned      cand;
    logic [VDNUM-1:0] shifted;

    // First requesting drive found when walking the ring from rr_ptr.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        shifted   = '0;
        for (int unsigned k = 0; k < VDNUM; k++) begin
            cand = {30'd0, rr_ptr} + k;
            if (cand >= VDNUM) begin
                cand = cand - VDNUM;
            end
            shifted = req >> cand;
            if (!gnt_valid && shifted[0]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[1:0];
            end
        end
    end

endmodule

// File: rtl/sd_io_sched.sv
// Arbitrates per-drive sector requests onto the single hps_io SD path,
// tracks the sd_ack handshake and reports completion / timeout / abort.
module sd_io_sched
    import sd_io_sched_pkg::*;
#(
    parameter int unsigned     VDNUM   = 3,
    parameter int unsigned     TO_W    = 24,
    parameter logic [TO_W-1:0] TIMEOUT = TO_W'(DEF_TIMEOUT)
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [VDNUM-1:0]      req_valid,
    input  logic [VDNUM-1:0]      req_write,
    input  logic [32*VDNUM-1:0]   req_lba,
    output logic [VDNUM-1:0]      req_ready,
    output logic [VDNUM-1:0]      done,
    output logic [VDNUM-1:0]      err,
    output logic                  busy,
    output logic [1:0]            cur_drv,
    output logic [31:0]           sd_lba,
    output logic [VDNUM-1:0]      sd_rd,
    output logic [VDNUM-1:0]      sd_wr,
    input  logic                  sd_ack,
    input  logic [VDNUM-1:0]      img_mounted
);

    sched_state_t     state;
    logic [1:0]       rr_ptr;
    logic             op_wr;
    logic [TO_W-1:0]  cnt;
    logic [TO_W-1:0]  cnt_inc;
    logic [1:0]       gnt_idx;
    logic             gnt_valid;
    logic [VDNUM-1:0] gnt_oh;
    logic [VDNUM-1:0] drv_oh;
    logic [31:0]      gnt_lba;
    logic             abort;
    logic             timeout;

    rr_arbiter #(
        .VDNUM(VDNUM)
    ) u_arb (
        .req      (req_valid),
        .rr_ptr   (rr_ptr),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid)
    );

    assign gnt_oh  = VDNUM'(1) << gnt_idx;
    assign drv_oh  = VDNUM'(1) << cur_drv;
    assign gnt_lba = 32'(req_lba >> {gnt_idx, 5'd0});
    assign cnt_inc = cnt + TO_W'(1);
    assign timeout = (cnt_inc == TIMEOUT);
    assign abort   = |(img_mounted & drv_oh);
    assign busy    = (state != S_IDLE);

    // Scheduler FSM with registered grant, strobe and completion outputs.
    // done/err are loaded on the edge entering FIN so they are visible
    // during the FIN cycle itself.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            op_wr     <= 1'b0;
            cnt       <= '0;
            req_ready <= '0;
            done      <= '0;
            err       <= '0;
            cur_drv   <= '0;
            sd_lba    <= '0;
            sd_rd     <= '0;
            sd_wr     <= '0;
        end else begin
            req_ready <= '0;
            done      <= '0;
            err       <= '0;
            case (state)
                S_IDLE: begin
                    if (gnt_valid) begin
                        cur_drv   <= gnt_idx;
                        sd_lba    <= gnt_lba;
                        op_wr     <= |(req_write & gnt_oh);
                        req_ready <= gnt_oh;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt <= '0;
                    if (op_wr) begin
                        sd_wr <= drv_oh;
                    end else begin
                        sd_rd <= drv_oh;
                    end
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    cnt <= cnt_inc;
                    if (sd_ack) begin
                        sd_rd <= '0;
                        sd_wr <= '0;
                        state <= S_XFER;
                    end else if (abort || timeout) begin
                        sd_rd <= '0;
                        sd_wr <= '0;
                        done  <= drv_oh;
                        err   <= drv_oh;
                        state <= S_FIN;
                    end
                end
                S_XFER: begin
                    cnt <= cnt_inc;
                    if (!sd_ack) begin
                        done  <= drv_oh;
                        state <= S_FIN;
                    end else if (timeout) begin
                        done  <= drv_oh;
                        err   <= drv_oh;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    rr_ptr <= rr_next(cur_drv, VDNUM);
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_io_sched.sv
// Scoreboard bench for sd_io_sched: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_sd_io_sched;

    localparam int EV_GRANT = 0;
    localparam int EV_STRB  = 1;
    localparam int EV_SOFF  = 2;
    localparam int EV_DONE  = 3;
    localparam int EV_IDLE  = 4;

    typedef struct {
        int          kind;
        logic [5:0]  vec;
        logic [31:0] lba;
        logic [1:0]  drv;
        int          cyc;
    } exp_t;

    logic        clk_sys;
    logic        reset_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_write;
    logic [95:0] req_lba;
    logic [2:0]  req_ready;
    logic [2:0]  done;
    logic [2:0]  err;
    logic        busy;
    logic [1:0]  cur_drv;
    logic [31:0] sd_lba;
    logic [2:0]  sd_rd;
    logic [2:0]  sd_wr;
    logic        sd_ack;
    logic [2:0]  img_mounted;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    logic       ack_en = 1'b0;
    int         ack_delay = 4;
    int         ack_len = 10;
    logic [5:0] prev_strb = '0;
    logic       prev_busy = 1'b0;
    logic [5:0] strb;

    sd_io_sched #(
        .VDNUM  (3),
        .TO_W   (24),
        .TIMEOUT(24'd20)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_lba    (req_lba),
        .req_ready  (req_ready),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .cur_drv    (cur_drv),
        .sd_lba     (sd_lba),
        .sd_rd      (sd_rd),
        .sd_wr      (sd_wr),
        .sd_ack     (sd_ack),
        .img_mounted(img_mounted)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic push(input int kind, input logic [5:0] vec, input logic [31:0] lba,
                        input logic [1:0] drv, input int at);
        exp_t e;
        e.kind = kind;
        e.vec  = vec;
        e.lba  = lba;
        e.drv  = drv;
        e.cyc  = at;
        q.push_back(e);
    endtask

    task automatic take(input int kind, input logic [5:0] vec, input logic [31:0] lba,
                        input logic [1:0] drv);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d actual kind=%0d vec=%b required no event",
                     cyc, kind, vec);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.vec !== vec || e.lba !== lba || e.drv !== drv || e.cyc != cyc) begin
                errors++;
                $display("FAIL event actual kind=%0d vec=%b lba=%h drv=%0d cyc=%0d required kind=%0d vec=%b lba=%h drv=%0d cyc=%0d",
                         kind, vec, lba, drv, cyc, e.kind, e.vec, e.lba, e.drv, e.cyc);
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: turns DUT output activity into events checked against the queue.
    always @(negedge clk_sys) begin
        strb = {sd_wr, sd_rd};
        if (req_ready != 3'b000) take(EV_GRANT, {3'b000, req_ready}, sd_lba, cur_drv);
        if (prev_strb == 6'd0 && strb != 6'd0) take(EV_STRB, strb, 32'd0, 2'd0);
        if (prev_strb != 6'd0 && strb == 6'd0) take(EV_SOFF, 6'd0, 32'd0, 2'd0);
        if (done != 3'b000 || err != 3'b000) take(EV_DONE, {done, err}, 32'd0, 2'd0);
        if (prev_busy && !busy) take(EV_IDLE, 6'd0, 32'd0, 2'd0);
        if (strb != 6'd0) begin
            checks++;
            if (!$onehot(strb)) begin
                errors++;
                $display("FAIL strobe_onehot actual=%b required one bit", strb);
            end
        end
        prev_strb = strb;
        prev_busy = busy;
    end

    // hps_io model: acks a fixed delay after a strobe, for a fixed length.
    initial begin
        sd_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (ack_en && reset_n && (sd_rd != 3'b000 || sd_wr != 3'b000)) begin
                repeat (ack_delay) @(negedge clk_sys);
                sd_ack = 1'b1;
                repeat (ack_len) @(negedge clk_sys);
                sd_ack = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk_sys);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    task automatic serve_ready(input int budget);
        for (int k = 0; k < budget && req_valid != 3'b000; k++) begin
            @(negedge clk_sys);
            req_valid = req_valid & ~req_ready;
        end
    endtask

    initial begin
        int c;
        int c2;
        reset_n     = 1'b1;
        req_valid   = '0;
        req_write   = '0;
        req_lba     = '0;
        img_mounted = '0;
        #1 reset_n = 1'b0;
        #1;
        chk("reset_outputs", {26'd0, req_ready, done, err, busy, cur_drv, sd_rd, sd_wr},
            64'd0);
        chk("reset_lba", {32'd0, sd_lba}, 64'd0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Single read on drive 1.
        ack_en = 1'b1; ack_delay = 4; ack_len = 10;
        c = cyc;
        req_lba = '0;
        req_lba[63:32] = 32'h0000_0123;
        req_write = 3'b000;
        req_valid = 3'b010;
        push(EV_GRANT, 6'b000_010, 32'h123, 2'd1, c + 1);
        push(EV_STRB,  6'b000_010, 32'd0, 2'd0, c + 2);
        push(EV_SOFF,  6'b000_000, 32'd0, 2'd0, c + 7);
        push(EV_DONE,  6'b010_000, 32'd0, 2'd0, c + 17);
        push(EV_IDLE,  6'b000_000, 32'd0, 2'd0, c + 18);
        wait_until(c + 1);
        req_valid = '0;
        wait_until(c + 10);
        chk("t1_lba_hold", {32'd0, sd_lba}, 64'h123);
        chk("t1_drv_hold", {62'd0, cur_drv}, 64'd1);
        wait_until(c + 20);
        chk("t1_lba_after_fin", {32'd0, sd_lba}, 64'h123);
        do_reset();

        // Three simultaneous requests: 0 write, 1 read, 2 read.
        ack_delay = 2; ack_len = 4;
        @(negedge clk_sys);
        c = cyc;
        req_lba = {32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};
        req_write = 3'b001;
        req_valid = 3'b111;
        push(EV_GRANT, 6'b000_001, 32'hA0, 2'd0, c + 1);
        push(EV_STRB,  6'b001_000, 32'd0, 2'd0, c + 2);
        push(EV_SOFF,  6'b000_000, 32'd0, 2'd0, c + 5);
        push(EV_DONE,  6'b001_000, 32'd0, 2'd0, c + 9);
        push(EV_IDLE,  6'b000_000, 32'd0, 2'd0, c + 10);
        push(EV_GRANT, 6'b000_010, 32'hB1, 2'd1, c + 11);
        push(EV_STRB,  6'b000_010, 32'd0, 2'd0, c + 12);
        push(EV_SOFF,  6'b000_000, 32'd0, 2'd0, c + 15);
        push(EV_DONE,  6'b010_000, 32'd0, 2'd0, c + 19);
        push(EV_IDLE,  6'b000_000, 32'd0, 2'd0, c + 20);
        push(EV_GRANT, 6'b000_100, 32'hC2, 2'd2, c + 21);
        push(EV_STRB,  6'b000_100, 32'd0, 2'd0, c + 22);
        push(EV_SOFF,  6'b000_000, 32'd0, 2'd0, c + 25);
        push(EV_DONE,  6'b100_000, 32'd0, 2'd0, c + 29);
        push(EV_IDLE,  6'b000_000, 32'd0, 2'd0, c + 30);
        serve_ready(60);
        req_valid = '0;
        wait_until(c + 33);

        // Drive 2 write with no ack: timeout after 20 strobe cycles.
        ack_en = 1'b0;
        c = cyc;
        req_lba = '0;
        req_lba[95:64] = 32'hDEAD_0002;
        req_write = 3'b100;
        req_valid = 3'b100;
        push(EV_GRANT, 6'b000_100, 32'hDEAD_0002, 2'd2, c + 1);
        push(EV_STRB,  6'b100_000, 32'd0, 2'd0, c + 2);
        push(EV_SOFF,  6'b000_000, 32'd0, 2'd0, c + 22);
        push(EV_DONE,  6'b100_100, 32'd0, 2'd0, c + 22);
        push(EV_IDLE,  6'b000_000, 32'd0, 2'd0, c + 23);
        wait_until(c + 1);
        req_valid = '0;
        wait_until(c + 26);

        // Drive 0 read aborted by a mount pulse while waiting for ack.
        c = cyc;
        req_lba = '0;
        req_lba[31:0] = 32'h0000_0400;
        req_write = 3'b000;
        req_valid = 3'b001;
        push(EV_GRANT, 6'b000_001, 32'h400, 2'd0, c + 1);
        push(EV_STRB,  6'b000_001, 32'd0, 2'd0, c + 2);
        push(EV_SOFF,  6'b000_000, 32'd0, 2'd0, c + 6);
        push(EV_DONE,  6'b001_001, 32'd0, 2'd0, c + 6);
        push(EV_IDLE,  6'b000_000, 32'd0, 2'd0, c + 7);
        wait_until(c + 1);
        req_valid = '0;
        wait_until(c + 5);
        img_mounted = 3'b001;
        wait_until(c + 6);
        img_mounted = '0;
        wait_until(c + 10);

        // Drive 1 read with a mount pulse during the transfer: no error.
        ack_en = 1'b1; ack_delay = 2; ack_len = 6;
        c = cyc;
        req_lba = '0;
        req_lba[63:32] = 32'h0000_0555;
        req_valid = 3'b010;
        push(EV_GRANT, 6'b000_010, 32'h555, 2'd1, c + 1);
        push(EV_STRB,  6'b000_010, 32'd0, 2'd0, c + 2);
        push(EV_SOFF,  6'b000_000, 32'd0, 2'd0, c + 5);
        push(EV_DONE,  6'b010_000, 32'd0, 2'd0, c + 11);
        push(EV_IDLE,  6'b000_000, 32'd0, 2'd0, c + 12);
        wait_until(c + 1);
        req_valid = '0;
        wait_until(c + 7);
        img_mounted = 3'b010;
        wait_until(c + 8);
        img_mounted = '0;
        wait_until(c + 15);

        // Reset during a drive 2 transfer, then drives 0 and 2 request.
        ack_delay = 2; ack_len = 10;
        c = cyc;
        req_lba = '0;
        req_lba[95:64] = 32'h0000_0077;
        req_valid = 3'b100;
        push(EV_GRANT, 6'b000_100, 32'h77, 2'd2, c + 1);
        push(EV_STRB,  6'b000_100, 32'd0, 2'd0, c + 2);
        push(EV_SOFF,  6'b000_000, 32'd0, 2'd0, c + 5);
        push(EV_IDLE,  6'b000_000, 32'd0, 2'd0, c + 8);
        wait_until(c + 1);
        req_valid = '0;
        wait_until(c + 7);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_busy", {63'd0, busy}, 64'd0);
        chk("t5_async_strobes", {58'd0, sd_wr, sd_rd}, 64'd0);
        chk("t5_async_state", {30'd0, cur_drv, sd_lba}, 64'd0);
        wait_until(c + 8);
        reset_n = 1'b1;
        wait_until(c + 20);
        ack_len = 4;
        c2 = cyc;
        req_lba = {32'h0000_3000, 32'h0000_0000, 32'h0000_1000};
        req_write = 3'b000;
        req_valid = 3'b101;
        push(EV_GRANT, 6'b000_001, 32'h1000, 2'd0, c2 + 1);
        push(EV_STRB,  6'b000_001, 32'd0, 2'd0, c2 + 2);
        push(EV_SOFF,  6'b000_000, 32'd0, 2'd0, c2 + 5);
        push(EV_DONE,  6'b001_000, 32'd0, 2'd0, c2 + 9);
        push(EV_IDLE,  6'b000_000, 32'd0, 2'd0, c2 + 10);
        push(EV_GRANT, 6'b000_100, 32'h3000, 2'd2, c2 + 11);
        push(EV_STRB,  6'b000_100, 32'd0, 2'd0, c2 + 12);
        push(EV_SOFF,  6'b000_000, 32'd0, 2'd0, c2 + 15);
        push(EV_DONE,  6'b100_000, 32'd0, 2'd0, c2 + 19);
        push(EV_IDLE,  6'b000_000, 32'd0, 2'd0, c2 + 20);
        serve_ready(60);
        req_valid = '0;
        wait_until(c2 + 24);

        chk("pending_expectations", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
